// File: rtl/ss_stack_if.sv
// ss_io stack command/response bundle between the Forth core (master) and one stack (slave).
interface ss_stack_if #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DSZ   = 32
);
  localparam int unsigned SSZ = $clog2(DEPTH);

  logic           en;
  logic [1:0]     op;
  logic [DSZ-1:0] vi;
  logic           busy;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] s0;
  logic [SSZ-1:0] sp;
  logic [SSZ-1:0] sp_1;
  logic           ovf;
  logic           udf;

  modport master (
    output en, op, vi,
    input  busy, tos, s0, sp, sp_1, ovf, udf
  );

  modport slave (
    input  en, op, vi,
    output busy, tos, s0, sp, sp_1, ovf, udf
  );
endinterface

// File: rtl/ss_stack.sv
// Data/return stack: TOS and second item in registers, deeper cells in a sync-read RAM.
module ss_stack #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DSZ   = 32
) (
  input logic         clk,
  input logic         rst,
  ss_stack_if.slave   bus
);
  localparam int unsigned SSZ = $clog2(DEPTH);

  typedef enum logic [1:0] {SsLoad = 2'b00, SsPush = 2'b01, SsPop = 2'b10, SsPick = 2'b11} sop_e;
  typedef enum logic [1:0] {StIdle, StRefill, StPick} state_e;

  state_e         state_q, state_d;
  logic [DSZ-1:0] tos_q, tos_d;
  logic [DSZ-1:0] s0_q, s0_d;
  logic [SSZ-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;

  logic [DSZ-1:0] mem [DEPTH];
  logic [DSZ-1:0] rdata_q;
  logic           mem_we, mem_re;
  logic [SSZ-1:0] mem_wa, mem_ra;
  logic [DSZ-1:0] mem_wd;
  logic [DSZ-1:0] sp_ext;

  assign sp_ext = DSZ'(sp_q);

  always_comb begin
    state_d = state_q;
    tos_d   = tos_q;
    s0_d    = s0_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    mem_wa  = sp_q;
    mem_wd  = tos_q;
    mem_ra  = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          unique case (sop_e'(bus.op))
            SsLoad: tos_d = bus.vi;
            SsPush: begin
              if (sp_q == SSZ'(DEPTH - 1)) begin
                ovf_d = 1'b1;
              end else begin
                mem_we = 1'b1;
                s0_d   = tos_q;
                tos_d  = bus.vi;
                sp_d   = sp_q + SSZ'(1);
              end
            end
            SsPop: begin
              if (sp_q == '0) begin
                udf_d = 1'b1;
              end else begin
                tos_d = s0_q;
                sp_d  = sp_q - SSZ'(1);
                if (sp_q == SSZ'(1)) begin
                  s0_d = '0;
                end else begin
                  // New s0 is the cell under the one just promoted to TOS.
                  mem_re  = 1'b1;
                  mem_ra  = sp_q - SSZ'(2);
                  state_d = StRefill;
                end
              end
            end
            SsPick: begin
              if (tos_q >= sp_ext) begin
                udf_d = 1'b1;
              end else begin
                mem_re  = 1'b1;
                mem_ra  = sp_q - SSZ'(1) - tos_q[SSZ-1:0];
                state_d = StPick;
              end
            end
            default: ;
          endcase
        end
      end
      StRefill: begin
        s0_d    = rdata_q;
        state_d = StIdle;
      end
      StPick: begin
        tos_d   = rdata_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tos_q   <= '1;
      s0_q    <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      s0_q    <= s0_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_wa] <= mem_wd;
    end
    if (mem_re && !rst) begin
      rdata_q <= mem[mem_ra];
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.tos  = tos_q;
  assign bus.s0   = s0_q;
  assign bus.sp   = sp_q;
  assign bus.sp_1 = sp_q + SSZ'(DEPTH - 1);
  assign bus.ovf  = ovf_q;
  assign bus.udf  = udf_q;
endmodule

// File: tb/tb_ss_stack.sv
// Directed bench for ss_stack: vector table plus hand-written busy/reset/overflow sequences.
module tb_ss_stack;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DSZ   = 32;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PICK = 2'b11;
  localparam logic [31:0] NEG1 = 32'hffff_ffff;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] vi;
    logic [31:0] tos;
    logic [31:0] s0;
    logic [31:0] sp;
    logic        ovf;
    logic        udf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  vec_t vecs [21];
  int   nvec = 0;

  ss_stack_if #(.DEPTH(DEPTH), .DSZ(DSZ)) bus ();
  ss_stack #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Callers are always positioned just after a negedge.
  task automatic step(input logic e, input logic [1:0] o, input logic [31:0] v);
    bus.en = e;
    bus.op = o;
    bus.vi = v;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 8) begin
      step(1'b0, OP_LOAD, 32'd0);
      k++;
    end
    if (bus.busy) begin
      total++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", k);
    end
  endtask

  task automatic cmd(input logic [1:0] o, input logic [31:0] v);
    step(1'b1, o, v);
    bus.en = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, OP_LOAD, 32'd0);
    step(1'b0, OP_LOAD, 32'd0);
    rst = 1'b0;
  endtask

  task automatic add(input logic [1:0] o, input logic [31:0] v, input logic [31:0] t,
                     input logic [31:0] s, input logic [31:0] p, input logic ov,
                     input logic ud);
    vecs[nvec] = '{o, v, t, s, p, ov, ud};
    nvec++;
  endtask

  initial begin
    add(OP_LOAD,  1,  1,  0, 0, 0, 0);
    add(OP_PUSH,  2,  2,  1, 1, 0, 0);
    add(OP_PUSH,  3,  3,  2, 2, 0, 0);
    add(OP_POP,   0,  2,  1, 1, 0, 0);
    add(OP_POP,   0,  1,  0, 0, 0, 0);
    add(OP_POP,   0,  1,  0, 0, 0, 1);
    add(OP_LOAD, 10, 10,  0, 0, 0, 1);
    add(OP_PUSH, 20, 20, 10, 1, 0, 1);
    add(OP_PUSH, 30, 30, 20, 2, 0, 1);
    add(OP_PUSH, 40, 40, 30, 3, 0, 1);
    add(OP_LOAD,  2,  2, 30, 3, 0, 1);
    add(OP_PICK,  0, 10, 30, 3, 0, 1);
    add(OP_LOAD,  0,  0, 30, 3, 0, 1);
    add(OP_PICK,  0, 30, 30, 3, 0, 1);
    add(OP_LOAD,  1,  1, 30, 3, 0, 1);
    add(OP_PICK,  0, 20, 30, 3, 0, 1);
    add(OP_LOAD,  3,  3, 30, 3, 0, 1);
    add(OP_PICK,  0,  3, 30, 3, 0, 1);
    add(OP_POP,   0, 30, 20, 2, 0, 1);
    add(OP_LOAD,  5,  5, 20, 2, 0, 1);
    add(OP_PICK,  0,  5, 20, 2, 0, 1);

    bus.en = 1'b0;
    bus.op = OP_LOAD;
    bus.vi = '0;
    @(negedge clk);
    do_reset();

    chk("rst tos", bus.tos, NEG1);
    chk("rst s0", bus.s0, 32'd0);
    chk("rst sp", 32'(bus.sp), 32'd0);
    chk("rst sp_1", 32'(bus.sp_1), 32'(DEPTH - 1));
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst ovf", 32'(bus.ovf), 32'd0);
    chk("rst udf", 32'(bus.udf), 32'd0);

    for (int i = 0; i < nvec; i++) begin
      cmd(vecs[i].op, vecs[i].vi);
      chk($sformatf("v%0d tos", i), bus.tos, vecs[i].tos);
      chk($sformatf("v%0d s0", i), bus.s0, vecs[i].s0);
      chk($sformatf("v%0d sp", i), 32'(bus.sp), vecs[i].sp);
      chk($sformatf("v%0d ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d udf", i), 32'(bus.udf), 32'(vecs[i].udf));
    end

    // POP refill timing, with PUSH 7 held on en across the busy cycle.
    do_reset();
    cmd(OP_LOAD, 1);
    cmd(OP_PUSH, 2);
    cmd(OP_PUSH, 3);
    step(1'b1, OP_POP, 0);
    chk("pop1 busy", 32'(bus.busy), 32'd1);
    chk("pop1 tos", bus.tos, 32'd2);
    chk("pop1 sp", 32'(bus.sp), 32'd1);
    step(1'b1, OP_PUSH, 7);
    chk("refill busy", 32'(bus.busy), 32'd0);
    chk("refill s0", bus.s0, 32'd1);
    chk("refill tos", bus.tos, 32'd2);
    chk("refill sp", 32'(bus.sp), 32'd1);
    step(1'b1, OP_PUSH, 7);
    bus.en = 1'b0;
    chk("held push tos", bus.tos, 32'd7);
    chk("held push s0", bus.s0, 32'd2);
    chk("held push sp", 32'(bus.sp), 32'd2);
    chk("sp_1 at 2", 32'(bus.sp_1), 32'd1);

    // Pop to empty: the final POP must not raise busy.
    cmd(OP_POP, 0);
    chk("pop2 s0", bus.s0, 32'd1);
    step(1'b1, OP_POP, 0);
    bus.en = 1'b0;
    chk("pop3 busy", 32'(bus.busy), 32'd0);
    chk("pop3 tos", bus.tos, 32'd1);
    chk("pop3 sp", 32'(bus.sp), 32'd0);
    chk("pop3 s0", bus.s0, 32'd0);
    chk("sp_1 at 0", 32'(bus.sp_1), 32'(DEPTH - 1));

    // Reset during PICK aborts the read.
    cmd(OP_PUSH, 20);
    cmd(OP_LOAD, 0);
    step(1'b1, OP_PICK, 0);
    bus.en = 1'b0;
    chk("pick busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step(1'b0, OP_LOAD, 0);
    rst = 1'b0;
    chk("pick rst tos", bus.tos, NEG1);
    chk("pick rst s0", bus.s0, 32'd0);
    chk("pick rst sp", 32'(bus.sp), 32'd0);
    chk("pick rst busy", 32'(bus.busy), 32'd0);
    step(1'b0, OP_LOAD, 0);
    chk("pick rst tos+1", bus.tos, NEG1);

    // Underflow from reset state, once via POP and once via PICK.
    cmd(OP_POP, 0);
    chk("udf pop", 32'(bus.udf), 32'd1);
    chk("udf pop tos", bus.tos, NEG1);
    chk("udf pop busy", 32'(bus.busy), 32'd0);
    do_reset();
    cmd(OP_PICK, 0);
    chk("udf pick", 32'(bus.udf), 32'd1);
    chk("udf pick tos", bus.tos, NEG1);
    chk("udf pick ovf", 32'(bus.ovf), 32'd0);

    // Fill to DEPTH-1, overflow, then drain in LIFO order.
    do_reset();
    for (int i = 1; i < DEPTH; i++) cmd(OP_PUSH, 32'(i));
    chk("full sp", 32'(bus.sp), 32'(DEPTH - 1));
    chk("full tos", bus.tos, 32'(DEPTH - 1));
    chk("full ovf", 32'(bus.ovf), 32'd0);
    cmd(OP_PUSH, 99);
    chk("ovf flag", 32'(bus.ovf), 32'd1);
    chk("ovf tos", bus.tos, 32'(DEPTH - 1));
    chk("ovf sp", 32'(bus.sp), 32'(DEPTH - 1));
    for (int j = 1; j < DEPTH; j++) begin
      cmd(OP_POP, 0);
      chk($sformatf("drain%0d tos", j), bus.tos, (j == DEPTH - 1) ? NEG1 : 32'(DEPTH - 1 - j));
      chk($sformatf("drain%0d sp", j), 32'(bus.sp), 32'(DEPTH - 1 - j));
    end
    chk("ovf sticky", 32'(bus.ovf), 32'd1);
    chk("drain udf", 32'(bus.udf), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
